dma_bus_arbiter: RTL and testbench
==================================

Name: dma_bus_arbiter

Overview:
Sequences 68030 bus mastership for the SCSI DMA engine. It decides when the DMA side needs the bus from FIFO state and direction. It runs the _BR/_BG/_BGACK handshake and grants individual bus cycles to the CPU-side transfer state machine. It releases the bus at a clean cycle boundary on burst limit, FIFO condition, bus error or DMA disable. It replaces ad-hoc BREQ/OWN generation and feeds BREQ/BGACK to the top-level pin drivers.

Parameters:
MAX_BURST, 8, max longword bus cycles per bus tenure (1..255)
HOLDOFF, 4, idle clocks after release before BREQ may reassert (1..15)

Ports:
CLK  input  1  system clock (SCLK); all logic on rising edge
RESET_  input  1  asynchronous active-low reset
DMAENA  input  1  DMA enabled (control register)
DMADIR  input  1  1 = memory->SCSI (fill FIFO from bus), 0 = SCSI->memory (drain FIFO to bus)
FIFOFULL  input  1  FIFO full
FIFOEMPTY  input  1  FIFO empty
FLUSHFIFO  input  1  flush request; allows draining a partial FIFO
aBGRANT_  input  1  asynchronous bus grant from CPU, active low
AS_  input  1  system address strobe, active low, asynchronous
BGACK_I_  input  1  system bus grant acknowledge, active low, asynchronous
BERR_  input  1  bus error, active low, asynchronous
CYCDONE  input  1  one-clock pulse: bus cycle just terminated (from CPU_SM)
BREQ  output  1  bus request, active high (top drives _BR low)
OWN  output  1  bus owned, active high (top drives _BGACK, enables AS_/DS_/R_W)
CYCGO  output  1  permission to start the next bus cycle, level
BERRFLAG  output  1  sticky: tenure aborted by bus error

Behaviour:
- Reset: state IDLE. BREQ=0, OWN=0, CYCGO=0, BERRFLAG=0. Burst counter=0. Holdoff counter=0.
- Synchronisers: aBGRANT_, AS_, BGACK_I_ and BERR_ each pass through 2 flops. Only synced versions (bg, as, bgk, berr) are used internally.
- NEED = DMAENA & ((DMADIR & FIFOEMPTY) | (~DMADIR & (FIFOFULL | (FLUSHFIFO & ~FIFOEMPTY)))).
- DONE (checked while owning) is true when any of the following holds:
  - ~DMAENA
  - berr
  - burst count == MAX_BURST
  - DMADIR & FIFOFULL
  - ~DMADIR & FIFOEMPTY
- States and transitions:
  - IDLE: NEED -> REQ, with BREQ=1 from the next clock.
  - REQ: BREQ=1. Leave when bg & ~as & ~bgk, i.e. synced grant asserted, AS_ negated and BGACK negated; go to OWNED with BREQ=0 and OWN=1 on the same edge. If NEED drops or DMAENA=0 before the grant, go to IDLE with BREQ=0.
  - OWNED: OWN=1. CYCGO=1 whenever ~DONE. Each CYCDONE increments the burst count (saturating at MAX_BURST). DONE -> DRAIN.
  - DRAIN: OWN=1, CYCGO=0. When no cycle is in flight, go to HOLD with OWN=0 on that edge. A cycle is in flight from the first CYCGO clock until CYCDONE. If CYCDONE arrives in the same clock as DONE, release immediately after it. Burst count clears on exit.
  - HOLD: BREQ=0, OWN=0. Count HOLDOFF clocks, then go to IDLE.
- berr while OWN sets BERRFLAG, sticky until RESET_ or DMAENA low. CYCGO drops the clock after berr is seen. No retry: HOLD, then IDLE, and NEED is masked while BERRFLAG=1.
- DMAENA falling while in REQ: BREQ drops on the next clock.
- DMAENA falling while owning: take the DRAIN path; the in-flight cycle is never cut short.
- CYCDONE outside OWNED/DRAIN is ignored.
- OWN and BREQ are never 1 on the same clock.
- OWN never rises while synced AS_ or BGACK_I_ is asserted.
- Latencies:
  - NEED to BREQ: 1 clock.
  - Grant to OWN: 2 sync clocks + 1 clock.
  - DONE to CYCGO low: 1 clock.
- Reset asserted mid-tenure: OWN, BREQ and CYCGO drop immediately (asynchronously).

Test Plan:
- DMADIR=0: FIFO goes full, grant after 5 clocks with AS_/BGACK_ high -> BREQ high 1 clk after FIFOFULL; OWN high 3 clks after grant; 8 CYCDONE pulses; OWN low the clk after the 8th; BREQ stays low for 4 clks.
- DMADIR=1, FIFO empty, FIFO goes full after 3 CYCDONEs -> CYCGO low the clk after FIFOFULL, OWN drops after the in-flight cycle's CYCDONE; burst count=3 then cleared.
- Grant given while AS_ still low (CPU cycle finishing) -> OWN stays 0 until 2 clks after AS_ rises, then OWN=1.
- BERR_ low during the 2nd cycle of a tenure -> BERRFLAG=1, CYCGO=0, OWN released after CYCDONE; no new BREQ while NEED=1 until DMAENA toggles low then high.
- FLUSHFIFO=1, DMADIR=0, FIFO half full -> request and ownership; release when FIFOEMPTY rises; no further BREQ after HOLD.
- RESET_ pulsed low while OWN=1 mid-cycle -> OWN, BREQ, CYCGO, BERRFLAG all 0 asynchronously; returns to IDLE.

Source files
------------

// File: rtl/dma_bus_arbiter_if.sv
// Handshake bundle between the SCSI DMA bus arbiter and the rest of the DMA block:
// FIFO status, raw 68030 bus lines, CPU_SM cycle handshake and the arbiter's pin requests.
interface dma_bus_arbiter_if;
  logic DMAENA;
  logic DMADIR;
  logic FIFOFULL;
  logic FIFOEMPTY;
  logic FLUSHFIFO;
  logic aBGRANT_;
  logic AS_;
  logic BGACK_I_;
  logic BERR_;
  logic CYCDONE;
  logic BREQ;
  logic OWN;
  logic CYCGO;
  logic BERRFLAG;

  modport slave (
    input  DMAENA, DMADIR, FIFOFULL, FIFOEMPTY, FLUSHFIFO,
    input  aBGRANT_, AS_, BGACK_I_, BERR_, CYCDONE,
    output BREQ, OWN, CYCGO, BERRFLAG
  );

  modport master (
    output DMAENA, DMADIR, FIFOFULL, FIFOEMPTY, FLUSHFIFO,
    output aBGRANT_, AS_, BGACK_I_, BERR_, CYCDONE,
    input  BREQ, OWN, CYCGO, BERRFLAG
  );
endinterface

// File: rtl/dma_bus_arbiter.sv
// 68030 bus-mastership sequencer for the SCSI DMA engine: runs the BR/BG/BGACK handshake,
// hands out bus cycles to CPU_SM and gives the bus back at a clean cycle boundary.
module dma_bus_arbiter #(
  parameter int MAX_BURST = 8,
  parameter int HOLDOFF   = 4
) (
  input  logic             CLK,
  input  logic             RESET_,
  dma_bus_arbiter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, REQ, OWNED, DRAIN, HOLD} state_t;

  localparam logic [7:0] BURST_MAX  = 8'(MAX_BURST);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [3:0] HOLD_LAST  = 4'(HOLDOFF - 1);

  state_t     state;
  state_t     next_state;
  logic [1:0] bg_sync;
  logic [1:0] as_sync;
  logic [1:0] bgk_sync;
  logic [1:0] berr_sync;
  logic [7:0] burst_cnt;
  logic [3:0] hold_cnt;
  logic       in_flight;
  logic       berr_flag;
  logic       bg;
  logic       as;
  logic       bgk;
  logic       berr;
  logic       need;
  logic       count_hit;
  logic       done;
  logic       grant_ok;
  logic       breq;
  logic       own;
  logic       cycgo;

  // Raw bus lines are active low; synchronisers reset to the negated level.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      bg_sync   <= 2'b11;
      as_sync   <= 2'b11;
      bgk_sync  <= 2'b11;
      berr_sync <= 2'b11;
    end else begin
      bg_sync   <= {bg_sync[0],   bus.aBGRANT_};
      as_sync   <= {as_sync[0],   bus.AS_};
      bgk_sync  <= {bgk_sync[0],  bus.BGACK_I_};
      berr_sync <= {berr_sync[0], bus.BERR_};
    end
  end

  assign bg   = ~bg_sync[1];
  assign as   = ~as_sync[1];
  assign bgk  = ~bgk_sync[1];
  assign berr = ~berr_sync[1];

  assign need = bus.DMAENA & ~berr_flag &
                ((bus.DMADIR & bus.FIFOEMPTY) |
                 (~bus.DMADIR & (bus.FIFOFULL | (bus.FLUSHFIFO & ~bus.FIFOEMPTY))));

  // Count the terminating cycle early so the last burst cycle releases on its own CYCDONE.
  assign count_hit = (burst_cnt == BURST_MAX) | (bus.CYCDONE & (burst_cnt == BURST_LAST));

  assign done = ~bus.DMAENA | berr | count_hit |
                (bus.DMADIR & bus.FIFOFULL) | (~bus.DMADIR & bus.FIFOEMPTY);

  assign grant_ok = bg & ~as & ~bgk;

  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (need) next_state = REQ;
      REQ: begin
        if (!need)         next_state = IDLE;
        else if (grant_ok) next_state = OWNED;
      end
      OWNED: if (done) next_state = bus.CYCDONE ? HOLD : DRAIN;
      DRAIN: if (!in_flight || bus.CYCDONE) next_state = HOLD;
      HOLD:  if (hold_cnt == HOLD_LAST) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    breq  = 1'b0;
    own   = 1'b0;
    cycgo = 1'b0;
    case (state)
      REQ:   breq = 1'b1;
      OWNED: begin
        own   = 1'b1;
        cycgo = 1'b1;
      end
      DRAIN: own = 1'b1;
      default: ;
    endcase
  end

  // A cycle is outstanding from the first clock CPU_SM sees CYCGO until its CYCDONE.
  always_ff @(posedge CLK or negedge RESET_) begin
    if (!RESET_) begin
      in_flight <= 1'b0;
      burst_cnt <= '0;
      hold_cnt  <= '0;
      berr_flag <= 1'b0;
    end else begin
      if (!own || bus.CYCDONE) in_flight <= 1'b0;
      else if (cycgo)          in_flight <= 1'b1;

      if (!own || next_state == HOLD)
        burst_cnt <= '0;
      else if (bus.CYCDONE && burst_cnt != BURST_MAX)
        burst_cnt <= burst_cnt + 8'd1;

      if (state == HOLD && next_state == HOLD) hold_cnt <= hold_cnt + 4'd1;
      else                                     hold_cnt <= '0;

      if (!bus.DMAENA)     berr_flag <= 1'b0;
      else if (berr && own) berr_flag <= 1'b1;
    end
  end

  assign bus.BREQ     = breq;
  assign bus.OWN      = own;
  assign bus.CYCGO    = cycgo;
  assign bus.BERRFLAG = berr_flag;

endmodule

// File: tb/tb_dma_bus_arbiter.sv
// Directed scoreboard bench for dma_bus_arbiter: stimulus queues expected
// {BREQ,OWN,CYCGO,BERRFLAG} per clock, a negedge monitor pops and compares.
module tb_dma_bus_arbiter;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  vec;
    string       name;
  } exp_t;

  logic        clk;
  logic        rst_n;
  int unsigned cyc;
  int          checks;
  int          failures;
  exp_t        exp_q[$];

  dma_bus_arbiter_if bus ();

  dma_bus_arbiter #(.MAX_BURST(8), .HOLDOFF(4)) dut (
    .CLK    (clk),
    .RESET_ (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: compare every expectation due this clock, flag any that were skipped.
  always @(negedge clk) begin
    int i;
    logic [3:0] act;
    act = {bus.BREQ, bus.OWN, bus.CYCGO, bus.BERRFLAG};
    i = 0;
    while (i < exp_q.size()) begin
      if (exp_q[i].cyc <= cyc) begin
        checks++;
        if (exp_q[i].cyc < cyc || act !== exp_q[i].vec) begin
          failures++;
          $display("[TB] FAIL %s: {BREQ,OWN,CYCGO,BERRFLAG} got %b expected %b (cycle %0d)",
                   exp_q[i].name, act, exp_q[i].vec, cyc);
        end
        exp_q.delete(i);
      end else begin
        i++;
      end
    end
    if (rst_n) begin
      checks++;
      if (bus.BREQ && bus.OWN) begin
        failures++;
        $display("[TB] FAIL breq_own_exclusive: got BREQ=%b OWN=%b expected not both 1 (cycle %0d)",
                 bus.BREQ, bus.OWN, cyc);
      end
    end
  end

  task automatic stepClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic ena, input logic dir, input logic full,
                               input logic empty, input logic flush);
    bus.DMAENA    = ena;
    bus.DMADIR    = dir;
    bus.FIFOFULL  = full;
    bus.FIFOEMPTY = empty;
    bus.FLUSHFIFO = flush;
  endtask

  task automatic checkOutput(input string name, input int unsigned delay, input logic [3:0] vec);
    exp_t e;
    e.cyc  = cyc + delay;
    e.vec  = vec;
    e.name = name;
    exp_q.push_back(e);
  endtask

  task automatic quiesce();
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.aBGRANT_ = 1'b1;
    bus.AS_      = 1'b1;
    bus.BGACK_I_ = 1'b1;
    bus.BERR_    = 1'b1;
    bus.CYCDONE  = 1'b0;
    stepClk(10);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    bus.aBGRANT_ = 1'b1;
    bus.AS_      = 1'b1;
    bus.BGACK_I_ = 1'b1;
    bus.BERR_    = 1'b1;
    bus.CYCDONE  = 1'b0;
    stepClk(2);
    checkOutput("reset", 0, 4'b0000);
    stepClk(1);
    rst_n = 1'b1;
    stepClk(4);

    $display("[TB] full-burst tenure, SCSI->memory");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t1_idle", 0, 4'b0000);
    checkOutput("t1_breq", 1, 4'b1000);
    stepClk(5);
    bus.aBGRANT_ = 1'b0;
    checkOutput("t1_grant_sync", 2, 4'b1000);
    checkOutput("t1_own", 3, 4'b0110);
    stepClk(3);
    bus.aBGRANT_ = 1'b1;
    for (int i = 0; i < 8; i++) begin
      bus.CYCDONE = 1'b0;
      stepClk(1);
      bus.CYCDONE = 1'b1;
      if (i == 3) checkOutput("t1_mid_burst", 0, 4'b0110);
      if (i == 7) begin
        checkOutput("t1_last_cycle", 0, 4'b0110);
        checkOutput("t1_release", 1, 4'b0000);
      end
      stepClk(1);
    end
    bus.CYCDONE = 1'b0;
    checkOutput("t1_holdoff", 3, 4'b0000);
    checkOutput("t1_holdoff_idle", 4, 4'b0000);
    checkOutput("t1_rereq", 5, 4'b1000);
    stepClk(5);
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("t1_need_drop", 1, 4'b0000);
    stepClk(1);
    quiesce();

    $display("[TB] memory->SCSI tenure ended by FIFO full");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    bus.aBGRANT_ = 1'b0;
    checkOutput("t2_breq", 1, 4'b1000);
    checkOutput("t2_own", 3, 4'b0110);
    stepClk(3);
    bus.aBGRANT_ = 1'b1;
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      bus.CYCDONE = 1'b0;
      stepClk(1);
      bus.CYCDONE = 1'b1;
      stepClk(1);
    end
    bus.CYCDONE = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    checkOutput("t2_full_seen", 0, 4'b0110);
    checkOutput("t2_cycgo_low", 1, 4'b0100);
    stepClk(2);
    checkOutput("t2_drain_wait", 0, 4'b0100);
    bus.CYCDONE = 1'b1;
    checkOutput("t2_release", 1, 4'b0000);
    stepClk(1);
    bus.CYCDONE = 1'b0;
    quiesce();

    $display("[TB] grant while CPU address strobe still asserted");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.AS_      = 1'b0;
    bus.aBGRANT_ = 1'b0;
    checkOutput("t3_breq", 1, 4'b1000);
    stepClk(6);
    checkOutput("t3_as_hold", 0, 4'b1000);
    bus.AS_ = 1'b1;
    checkOutput("t3_as_sync", 2, 4'b1000);
    checkOutput("t3_own", 3, 4'b0110);
    stepClk(3);
    bus.aBGRANT_ = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t3_disable_drain", 1, 4'b0100);
    stepClk(1);
    bus.CYCDONE = 1'b1;
    checkOutput("t3_release", 1, 4'b0000);
    stepClk(1);
    bus.CYCDONE = 1'b0;
    quiesce();

    $display("[TB] bus error on second cycle");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.aBGRANT_ = 1'b0;
    checkOutput("t4_breq", 1, 4'b1000);
    checkOutput("t4_own", 3, 4'b0110);
    stepClk(3);
    bus.aBGRANT_ = 1'b1;
    bus.CYCDONE  = 1'b0;
    stepClk(1);
    bus.CYCDONE = 1'b1;
    stepClk(1);
    bus.CYCDONE = 1'b0;
    bus.BERR_   = 1'b0;
    checkOutput("t4_berr_sync", 2, 4'b0110);
    checkOutput("t4_berrflag", 3, 4'b0101);
    stepClk(3);
    bus.CYCDONE = 1'b1;
    bus.BERR_   = 1'b1;
    checkOutput("t4_release", 1, 4'b0001);
    stepClk(1);
    bus.CYCDONE = 1'b0;
    checkOutput("t4_need_masked", 8, 4'b0001);
    stepClk(8);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_flag_clear", 1, 4'b0000);
    stepClk(1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_rereq", 1, 4'b1000);
    stepClk(1);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    checkOutput("t4_ena_drop_req", 1, 4'b0000);
    stepClk(1);
    quiesce();

    $display("[TB] flush of a partial FIFO");
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    bus.aBGRANT_ = 1'b0;
    checkOutput("t5_breq", 1, 4'b1000);
    checkOutput("t5_own", 3, 4'b0110);
    stepClk(3);
    bus.aBGRANT_ = 1'b1;
    bus.CYCDONE  = 1'b0;
    stepClk(1);
    bus.CYCDONE = 1'b1;
    stepClk(1);
    bus.CYCDONE = 1'b0;
    stepClk(1);
    bus.CYCDONE = 1'b1;
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    checkOutput("t5_last_cycle", 0, 4'b0110);
    checkOutput("t5_release", 1, 4'b0000);
    stepClk(1);
    bus.CYCDONE = 1'b0;
    checkOutput("t5_no_rereq", 8, 4'b0000);
    stepClk(8);
    quiesce();

    $display("[TB] reset asserted mid-cycle");
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    bus.aBGRANT_ = 1'b0;
    checkOutput("t6_own", 3, 4'b0110);
    stepClk(3);
    bus.aBGRANT_ = 1'b1;
    stepClk(1);
    rst_n = 1'b0;
    checkOutput("t6_async_reset", 0, 4'b0000);
    stepClk(2);
    rst_n = 1'b1;
    checkOutput("t6_idle", 0, 4'b0000);
    checkOutput("t6_rereq", 1, 4'b1000);
    stepClk(1);
    quiesce();

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) stepClk(1);
    while (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL %s: got never sampled expected %b at cycle %0d",
               exp_q[0].name, exp_q[0].vec, exp_q[0].cyc);
      exp_q.delete(0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
